// File: rtl/norm_sched.sv
// rtl/norm_sched.sv - two-requester leading-zero normaliser with a shared LZC
module norm_sched #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        ack1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_id,
  output logic [4:0]  out_count,
  output logic [15:0] out_norm,
  output logic        out_zero,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] operand_q;
  logic        id_q;
  logic        last_q;
  logic        ack0_q;
  logic        ack1_q;
  logic        out_valid_q;
  logic        out_id_q;
  logic [4:0]  out_count_q;
  logic [15:0] out_norm_q;
  logic        out_zero_q;

  logic        grant_id_d;
  logic [4:0]  lzc_d;
  logic [15:0] norm_d;

  // Arbitration: a tie goes to the requester not served last in round-robin
  // mode, otherwise requester 0; a lone request always wins.
  always_comb begin
    grant_id_d = 1'b0;
    if (req0 && req1) begin
      grant_id_d = (ROUND_ROBIN != 0) ? ~last_q : 1'b0;
    end else if (req1) begin
      grant_id_d = 1'b1;
    end
  end

  // Shared leading-zero counter on the captured operand; the highest set bit
  // is scanned last so it determines the count, and an all-zero operand gives 16.
  always_comb begin
    lzc_d = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (operand_q[i]) begin
        lzc_d = 5'(15 - i);
      end
    end
    norm_d = operand_q << lzc_d;
  end

  // Control FSM with all outputs registered; reset wins over any event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      operand_q   <= 16'h0000;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_count_q <= 5'd0;
      out_norm_q  <= 16'h0000;
      out_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            operand_q <= grant_id_d ? data1 : data0;
            id_q      <= grant_id_d;
            last_q    <= grant_id_d;
            ack0_q    <= ~grant_id_d;
            ack1_q    <= grant_id_d;
            state_q   <= CALC;
          end
        end
        CALC: begin
          ack0_q      <= 1'b0;
          ack1_q      <= 1'b0;
          out_count_q <= lzc_d;
          out_norm_q  <= norm_d;
          out_zero_q  <= (operand_q == 16'h0000);
          out_id_q    <= id_q;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          ack0_q      <= 1'b0;
          ack1_q      <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_count = out_count_q;
  assign out_norm  = out_norm_q;
  assign out_zero  = out_zero_q;
  assign busy      = (state_q != IDLE);

endmodule
